cla_seq_arbiter: RTL and testbench
==================================

CLA_SEQ_ARBITER -- requirements
Module: cla_seq_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous, active-low.
REQ-002 SHALL have reqN_valid in 1 (N=0,1), request present.
REQ-003 SHALL have reqN_ready out 1, request accepted this cycle.
REQ-004 SHALL have reqN_len in 2, word count minus one (0..3 = 16..64 bits).
REQ-005 SHALL have reqN_x in 64, operand X, little-endian 16-bit words.
REQ-006 SHALL have reqN_y in 64, operand Y, little-endian 16-bit words.
REQ-007 SHALL have reqN_sub in 1, subtract select; present only with CLA_SEQ_SUB_EN.
REQ-008 SHALL have rsp_valid out 1, result available.
REQ-009 SHALL have rsp_ready in 1, consumer accepts the result.
REQ-010 SHALL have rsp_id out 1, which requester owns the result.
REQ-011 SHALL have rsp_sum out 64, result; words above len are zero.
REQ-012 SHALL have rsp_cout out 1, carry out of the last word.
REQ-013 SHALL instantiate exactly one cla_16bits (x, y, c_in, s, c_out) as the only adder.

Function
REQ-014 SHALL implement FSM states IDLE, ADD, DONE.
REQ-015 IDLE: reqN_ready=1 only for the granted requester and only in IDLE; all other ready outputs are 0.
REQ-016 Grant: one valid request is granted directly; two valid requests are granted to the priority pointer holder.
REQ-017 Handshake edge (valid&ready): latch x, y, len, id and sub; word index=0; carry register=0 (or sub); go to ADD.
REQ-018 ADD: adder inputs are latched word[idx] of x and y (y inverted when sub) with c_in=carry register.
REQ-019 ADD, each edge: result word[idx] <= s, carry <= c_out, idx <= idx+1; go to DONE when idx==len.
REQ-020 Latency: rsp_valid SHALL rise len+2 edges after the accepting edge; throughput is one word per cycle.
REQ-021 DONE: rsp_valid=1; rsp_id, rsp_sum and rsp_cout held stable until rsp_valid&rsp_ready.
REQ-022 On response handshake: go to IDLE; pointer <= ~rsp_id; a new request is accepted no earlier than the next cycle.
REQ-023 Request changes while not granted SHALL have no effect; latched operands are immune to input changes after acceptance.
REQ-024 Word index SHALL not wrap: len=3 ends after idx 3.
REQ-025 rsp_cout SHALL be the c_out of word len only; no intermediate carries are exposed.

Reset
REQ-026 rst_n low SHALL asynchronously force: state=IDLE, pointer=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, carry=0, idx=0.
REQ-027 Reset mid-ADD or mid-DONE SHALL discard the transaction without any response.
REQ-028 The first grant after reset with both requests valid SHALL go to req0.

Configuration
REQ-029 Macro CLA_SEQ_SUB_EN defined: reqN_sub ports exist; sub=1 computes X-Y as X+~Y with initial carry 1; rsp_cout=1 means no borrow.
REQ-030 Macro CLA_SEQ_SUB_EN undefined: no sub ports; initial carry always 0; add only.

Verification
REQ-031 req0 len=0 x=0xFFFF y=0x0003 -> rsp_sum=0x0002, rsp_cout=1, rsp_id=0, rsp_valid 2 edges after acceptance.
REQ-032 req1 len=3 x=0xFFFF_FFFF_FFFF_FFFF y=1 -> rsp_sum=0, rsp_cout=1, rsp_valid 5 edges after acceptance; len=1 x=0x0000_FFFF y=1 -> rsp_sum=0x0000_0000_0001_0000, rsp_cout=0.
REQ-033 Both valid continuously after reset, rsp_ready=1 -> rsp_id sequence 0,1,0,1; neither requester is starved.
REQ-034 rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, both reqN_ready=0, and no new acceptance until the response handshake.
REQ-035 rst_n pulsed low during ADD of a len=3 request -> rsp_valid never asserts for it, outputs read 0, and the next request (0x1234+0x1111, len=0) returns 0x2345.
REQ-036 With CLA_SEQ_SUB_EN: len=1 x=0x0000_0005 y=0x0000_0007 sub=1 -> rsp_sum=0x0000_0000_FFFF_FFFE, rsp_cout=0; x=7 y=5 -> 0x0000_0000_0000_0002, rsp_cout=1.

Source files
------------

// File: rtl/cla_seq_arbiter.sv
// cla_seq_arbiter: two-requester arbiter in front of a single 16-bit carry
// lookahead adder. A granted request is added one 16-bit word per cycle
// (1..4 words), and the result is held on rsp_* until the consumer accepts it.
// Optional feature macro: CLA_SEQ_SUB_EN adds reqN_sub ports. With sub=1 the
// block computes X-Y as X+~Y with an initial carry of 1.

// 16-bit adder built from four 4-bit lookahead groups and a second-level
// lookahead across the groups.
module cla_16bits (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  assign w_g = x & y;
  assign w_p = x ^ y;

  // Group generate/propagate for each 4-bit block
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
    end
  end

  // Group carries, fully expanded so no carry ripples between groups
  assign w_gc[0] = c_in;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & c_in);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c_in);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & c_in);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]) | ((&w_gp) & c_in);

  // Bit carries inside each group, expanded from that group's carry-in
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  assign s     = w_p ^ w_c;
  assign c_out = w_gc[4];

endmodule

module cla_seq_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_len,
  input  logic [63:0] req0_x,
  input  logic [63:0] req0_y,
`ifdef CLA_SEQ_SUB_EN
  input  logic        req0_sub,
`endif
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_len,
  input  logic [63:0] req1_x,
  input  logic [63:0] req1_y,
`ifdef CLA_SEQ_SUB_EN
  input  logic        req1_sub,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_sum,
  output logic        rsp_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Control state
  state_t      r_state;
  logic        r_ptr;
  logic        r_carry;
  logic [1:0]  r_idx;

  // Latched request and working result
  logic [63:0] r_x;
  logic [63:0] r_y;
  logic [63:0] r_res;
  logic [1:0]  r_len;
  logic        r_id;
  logic        r_sub;

  // Registered response
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic        r_rsp_cout;
  logic [63:0] r_rsp_sum;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_req0_sub;
  logic        w_req1_sub;
  logic        w_sel_sub;
  logic [1:0]  w_sel_len;
  logic [63:0] w_sel_x;
  logic [63:0] w_sel_y;
  logic [5:0]  w_bit;
  logic [15:0] w_ax;
  logic [15:0] w_ay;
  logic [15:0] w_s;
  logic        w_cout;

`ifdef CLA_SEQ_SUB_EN
  assign w_req0_sub = req0_sub;
  assign w_req1_sub = req1_sub;
`else
  assign w_req0_sub = 1'b0;
  assign w_req1_sub = 1'b0;
`endif

  // A lone valid request wins outright; a tie goes to the pointer holder.
  assign w_grant0   = req0_valid & (~req1_valid | ~r_ptr);
  assign w_grant1   = req1_valid & (~req0_valid |  r_ptr);
  assign req0_ready = (r_state == S_IDLE) & w_grant0;
  assign req1_ready = (r_state == S_IDLE) & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_x    = w_grant1 ? req1_x     : req0_x;
  assign w_sel_y    = w_grant1 ? req1_y     : req0_y;
  assign w_sel_len  = w_grant1 ? req1_len   : req0_len;
  assign w_sel_sub  = w_grant1 ? w_req1_sub : w_req0_sub;

  // Current word of the latched operands; Y is inverted for subtraction.
  assign w_bit = {r_idx, 4'b0000};
  assign w_ax  = r_x[w_bit +: 16];
  assign w_ay  = r_y[w_bit +: 16] ^ {16{r_sub}};

  cla_16bits u_cla (
    .x     (w_ax),
    .y     (w_ay),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_cout)
  );

  // Capture the granted request and accumulate result words during ADD
  // NOTE: these registers are always rewritten before they are read, so they
  // carry no reset; the reset-visible state lives in the control block below.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x   <= w_sel_x;
      r_y   <= w_sel_y;
      r_len <= w_sel_len;
      r_id  <= w_grant1;
      r_sub <= w_sel_sub;
      r_res <= '0;
    end else if (r_state == S_ADD) begin
      r_res[w_bit +: 16] <= w_s;
    end
  end

  // Sequencing FSM: accept, add word by word, then publish and hold the result
  // NOTE: every register here is assigned with <= so all of them see the
  // pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_ADD;
            r_idx   <= 2'd0;
            r_carry <= w_sel_sub;
          end
        end
        S_ADD: begin
          r_carry <= w_cout;
          if (r_idx == r_len) begin
            // Last word: stop here so the 2-bit index never wraps.
            r_state <= S_DONE;
            r_idx   <= 2'd0;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        S_DONE: begin
          if (!r_rsp_valid) begin
            // r_carry now holds the carry out of the last word only.
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_sum   <= r_res;
            r_rsp_cout  <= r_carry;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= ~r_rsp_id;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_cla_seq_arbiter.sv
// tb_cla_seq_arbiter: directed and randomized transactions checked against an
// arithmetic reference model (masked wide add) and a round-robin grant model.
// Build with +define+CLA_SEQ_SUB_EN to include the subtract cases.
module tb_cla_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_len = '0, req1_len = '0;
  logic [63:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [63:0] rsp_sum;
  logic        rsp_cout;

  int   n_checks = 0;
  int   n_pass = 0;
  logic ptr_m = 1'b0;

  always #5 clk = ~clk;

  cla_seq_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_len   (req0_len),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
`ifdef CLA_SEQ_SUB_EN
    .req0_sub   (req0_sub),
`endif
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_len   (req1_len),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
`ifdef CLA_SEQ_SUB_EN
    .req1_sub   (req1_sub),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: {cout, sum} of the low (len+1)*16 bits, X + Y or X + ~Y + 1.
  function automatic logic [64:0] ref_op(input logic [1:0] len, input logic [63:0] x,
                                         input logic [63:0] y, input logic sub);
    int          nb;
    logic [64:0] mask, xm, ym, full;
    nb   = (int'(len) + 1) * 16;
    mask = (65'd1 << nb) - 65'd1;
    xm   = {1'b0, x} & mask;
    ym   = {1'b0, y} & mask;
    if (sub) ym = ~ym & mask;
    full = xm + ym + {64'd0, sub};
    return {full[nb], full[63:0] & mask[63:0]};
  endfunction

  function automatic logic rnd_sub();
`ifdef CLA_SEQ_SUB_EN
    return 1'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction from an idle DUT. Valids stay asserted (with
  // scrambled operands) after acceptance to show they have no effect.
  task automatic txn(input logic v0, input logic v1, input logic [1:0] l0, input logic [1:0] l1,
                     input logic [63:0] x0, input logic [63:0] y0,
                     input logic [63:0] x1, input logic [63:0] y1,
                     input logic s0, input logic s1, input int stall,
                     output logic got_id, output logic [63:0] got_sum, output logic got_cout);
    logic        g1;
    logic [1:0]  l;
    logic [64:0] exp;
    int          edges;
    req0_valid = v0; req0_len = l0; req0_x = x0; req0_y = y0; req0_sub = s0;
    req1_valid = v1; req1_len = l1; req1_x = x1; req1_y = y1; req1_sub = s1;
    rsp_ready  = (stall == 0);
    #1;
    g1  = v1 && (!v0 || ptr_m);
    exp = g1 ? ref_op(l1, x1, y1, s1) : ref_op(l0, x0, y0, s0);
    l   = g1 ? l1 : l0;
    check("grant_ready0", req0_ready, v0 && !g1);
    check("grant_ready1", req1_ready, g1);
    @(posedge clk); #1;
    req0_x = {$urandom, $urandom}; req0_y = {$urandom, $urandom}; req0_len = 2'($urandom);
    req1_x = {$urandom, $urandom}; req1_y = {$urandom, $urandom}; req1_len = 2'($urandom);
    req0_sub = rnd_sub(); req1_sub = rnd_sub();
    edges = 0;
    while (!rsp_valid && edges < 12) begin
      check("busy_ready0", req0_ready, 1'b0);
      check("busy_ready1", req1_ready, 1'b0);
      @(posedge clk); #1;
      edges++;
    end
    check("latency", 64'(edges), 64'(int'(l) + 2));
    got_id = rsp_id; got_sum = rsp_sum; got_cout = rsp_cout;
    check("rsp_id", rsp_id, g1);
    check("rsp_sum", rsp_sum, exp[63:0]);
    check("rsp_cout", rsp_cout, exp[64]);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_id", rsp_id, g1);
      check("hold_sum", rsp_sum, exp[63:0]);
      check("hold_cout", rsp_cout, exp[64]);
      check("hold_ready0", req0_ready, 1'b0);
      check("hold_ready1", req1_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rsp_released", rsp_valid, 1'b0);
    ptr_m = ~g1;
  endtask

  initial begin
    logic        id;
    logic [63:0] s;
    logic        c;
    logic [1:0]  v;
    logic [1:0]  ids [4];

    // Reset state
    #12;
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_id", rsp_id, 1'b0);
    check("rst_sum", rsp_sum, 64'd0);
    check("rst_cout", rsp_cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 1'b0;
    @(negedge clk);

    // Both requesters valid from reset: grants alternate starting with req0
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b1, 2'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 0, id, s, c);
      ids[i] = {1'b0, id};
    end
    check("rr_seq0", ids[0], 2'd0);
    check("rr_seq1", ids[1], 2'd1);
    check("rr_seq2", ids[2], 2'd0);
    check("rr_seq3", ids[3], 2'd1);

    // Single-word add with carry out of word 0
    txn(1'b1, 1'b0, 2'd0, 2'd0, 64'hFFFF, 64'h0003, 64'd0, 64'd0, 1'b0, 1'b0, 0, id, s, c);
    check("d1_sum", s, 64'h2);
    check("d1_cout", c, 1'b1);
    check("d1_id", id, 1'b0);

    // Four-word carry chain through every word
    txn(1'b0, 1'b1, 2'd0, 2'd3, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, id, s, c);
    check("d2_sum", s, 64'd0);
    check("d2_cout", c, 1'b1);

    // Carry between words, none out of the last word
    txn(1'b0, 1'b1, 2'd0, 2'd1, 64'd0, 64'd0, 64'h0000_FFFF, 64'd1, 1'b0, 1'b0, 0, id, s, c);
    check("d3_sum", s, 64'h0000_0000_0001_0000);
    check("d3_cout", c, 1'b0);

    // Consumer stalls for 5 cycles in DONE with both requesters waiting
    txn(1'b1, 1'b1, 2'd2, 2'd1, {$urandom, $urandom}, {$urandom, $urandom},
        {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 5, id, s, c);

    // Reset in the middle of a four-word add
    req0_valid = 1'b1; req1_valid = 1'b0; req0_len = 2'd3;
    req0_x = {$urandom, $urandom}; req0_y = {$urandom, $urandom}; req0_sub = 1'b0;
    #1;
    check("mid_accept", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_id", rsp_id, 1'b0);
    check("mid_rst_sum", rsp_sum, 64'd0);
    check("mid_rst_cout", rsp_cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("mid_no_rsp", rsp_valid, 1'b0);
    end
    txn(1'b1, 1'b0, 2'd0, 2'd0, 64'h1234, 64'h1111, 64'd0, 64'd0, 1'b0, 1'b0, 0, id, s, c);
    check("post_rst_sum", s, 64'h2345);

`ifdef CLA_SEQ_SUB_EN
    // Subtraction with and without borrow
    txn(1'b1, 1'b0, 2'd1, 2'd0, 64'd5, 64'd7, 64'd0, 64'd0, 1'b1, 1'b0, 0, id, s, c);
    check("sub1_sum", s, 64'h0000_0000_FFFF_FFFE);
    check("sub1_cout", c, 1'b0);
    txn(1'b1, 1'b0, 2'd1, 2'd0, 64'd7, 64'd5, 64'd0, 64'd0, 1'b1, 1'b0, 0, id, s, c);
    check("sub2_sum", s, 64'h2);
    check("sub2_cout", c, 1'b1);
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      txn(v[0], v[1], 2'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}, rnd_sub(), rnd_sub(),
          int'($urandom_range(0, 3)), id, s, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
